eeprom_mirror_rx: RTL and testbench
===================================

# eeprom_mirror_rx

Receiver for the serial mirror stream that the EEPROM emulation emits on every internal write or erase (SPIDo / SPISel / SPIClkRunning). It deserialises each frame, decodes it into a word address, data and operation kind, and queues the result for the downstream save-flash writer through a valid/ready FIFO. It sits between the emulator's SPI outputs and the flash write path, in the SClk domain.

## Interface

- DEPTH, 4, FIFO entries (power of two, ≥2)
- SClk  in  1  system clock, same as the emulator
- Reset  in  1  asynchronous, active-high reset
- EEPROMSize  in  2  eepromSize_128B / _1KB / _2KB / _NoEEPROM
- SPIDo  in  1  serial data, MSB first
- SPISel  in  1  frame select, active low
- SPIClkRunning  in  1  bit-valid qualifier
- FrameReady  in  1  downstream accepts head entry
- ErrorClear  in  1  clears sticky flags
- FrameValid  out  1  FIFO non-empty
- FrameKind  out  2  mirrorKind_Write / _WriteAll / _Erase / _EraseAll
- FrameAddr  out  10  word address, masked to size
- FrameData  out  16  write data; 16'hFFFF for erase kinds
- Busy  out  1  frame in progress
- FrameError  out  1  sticky: bad length or opcode
- Overflow  out  1  sticky: frame dropped, FIFO full

## Operation

- States: IDLE, SHIFT. IDLE→SHIFT on SPISel=0. SHIFT→IDLE on SPISel=1, which ends the frame (decode happens on that edge).
- In SHIFT, each edge with SPIClkRunning=1 and SPISel=0 shifts SPIDo into a 32-bit register and increments a 6-bit bit counter. The counter saturates at 33; bits beyond 32 are not stored.
- On frame end, command = first 16 bits; data = last 16 bits (32-bit frames only).
  - op = command[8:4] for 128B, command[12:8] otherwise.
  - Address mask: 0x3F / 0x1FF / 0x3FF.
- Decode:
  - 32 bits with op 101?? → Write, addr = command[9:0] & mask.
  - 32 bits with op 10001 → WriteAll, addr = 0.
  - 16 bits with op 111?? → Erase, addr = command[9:0] & mask.
  - 16 bits with op 10010 → EraseAll, addr = 0.
  - Any other count/op combination → discard and set FrameError.
- EEPROMSize = NoEEPROM: frames are received and discarded, with no push and no error.
- Valid frame with FIFO full: frame is dropped, Overflow set. Entries already queued are unaffected.
- Simultaneous push and pop on a full FIFO: the pop frees a slot first, so the push succeeds and there is no overflow.
- ErrorClear clears both sticky flags. If ErrorClear coincides with a new error event, the error wins (flag stays set).
- EEPROMSize changing mid-frame: the value sampled at frame end is used.

## Timing

- Reset values: state IDLE, FIFO empty, FrameValid=0, Busy=0, FrameError=0, Overflow=0. FrameKind/Addr/Data=0.
- Reset mid-frame aborts the frame with no push. Reset also flushes the FIFO.
- Busy is 1 from the edge after SPISel is first seen low until the frame-end edge.
- Latency: the entry is written on the frame-end edge. FrameValid is high in the following cycle.
- Emulator frame length: write/writeall = 32 qualified bits; erase/eraseall = 16 qualified bits.
  - For erase, one SPIDo cycle occurs after SPIClkRunning falls while SPISel is still low; the receiver ignores it.
- Handshake:
  - Entry pops on an edge with FrameValid && FrameReady.
  - FrameKind/Addr/Data stay stable while FrameValid && !FrameReady.
  - The FIFO output is registered (show-ahead); back-to-back pops give one entry per cycle.
- Minimum frame spacing: one idle cycle of SPISel high between frames is sufficient.

## Structure

- Shared package: EEPROMSizeTypes (moved out of the emulator), MirrorKind enum, address-mask and frame-length constants (16, 32).
- Sub-module eeprom_mirror_fifo: synchronous show-ahead FIFO, width 28, parameter DEPTH, with full/empty outputs.
- Top level holds the shifter, bit counter, FSM, decode and sticky flags.

## Test plan

- **1KB write:** command 0x1423, data 0xBEEF, 32 bits → one entry: Write, addr 0x023, data 0xBEEF.
- **1KB erase:** command 0x1C05, 16 bits plus one trailing SPIDo cycle → Erase, addr 0x005, data 0xFFFF.
- **128B write and 2KB erase-all:**
  - 128B: command 0x0147, data 0x1234 → Write, addr 0x07.
  - 2KB: command 0x1200, 16 bits → EraseAll, addr 0, data 0xFFFF.
- **Overflow:** FrameReady held 0, five valid frames → four entries retained in order, Overflow=1. Then FrameReady=1 → four pops on consecutive cycles.
- **Bad frames:**
  - 20-bit frame → FrameError=1, no push; ErrorClear → flag 0.
  - EEPROMSize=NoEEPROM with a valid write → no push, no error.
- **Reset mid-frame:** assert Reset after 10 bits → Busy=0, FIFO empty. The next full frame decodes correctly.

Source files
------------

// File: rtl/eeprom_mirror_rx_pkg.sv
// ----------------------------------------------------------------------------
// eeprom_mirror_rx_pkg
// Shared types and constants for the EEPROM mirror-stream receiver:
//   - EEPROMSizeTypes : emulated EEPROM size (also used by the emulator)
//   - MirrorKind      : decoded operation kind of a mirror frame
//   - mirror_entry_t  : one queued frame (kind, word address, data), 28 bits
//   - frame lengths, address masks and the erase fill pattern
// ----------------------------------------------------------------------------
package eeprom_mirror_rx_pkg;

    typedef enum logic [1:0] {
        eepromSize_128B     = 2'd0,
        eepromSize_1KB      = 2'd1,
        eepromSize_2KB      = 2'd2,
        eepromSize_NoEEPROM = 2'd3
    } EEPROMSizeTypes;

    typedef enum logic [1:0] {
        mirrorKind_Write    = 2'd0,
        mirrorKind_WriteAll = 2'd1,
        mirrorKind_Erase    = 2'd2,
        mirrorKind_EraseAll = 2'd3
    } MirrorKind;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        MirrorKind   kind;
        logic [9:0]  addr;
        logic [15:0] data;
    } mirror_entry_t;

    // Qualified bit counts of the two emulator frame shapes.
    localparam logic [5:0] FRAME_LEN_SHORT = 6'd16;
    localparam logic [5:0] FRAME_LEN_LONG  = 6'd32;
    // One past the longest frame, so over-long frames stay distinguishable.
    localparam logic [5:0] BIT_CNT_SAT     = 6'd33;

    localparam logic [9:0]  ADDR_MASK_128B = 10'h03F;
    localparam logic [9:0]  ADDR_MASK_1KB  = 10'h1FF;
    localparam logic [9:0]  ADDR_MASK_2KB  = 10'h3FF;
    localparam logic [15:0] ERASE_DATA     = 16'hFFFF;

    function automatic logic [9:0] addr_mask(input EEPROMSizeTypes size);
        case (size)
            eepromSize_128B: addr_mask = ADDR_MASK_128B;
            eepromSize_1KB:  addr_mask = ADDR_MASK_1KB;
            default:         addr_mask = ADDR_MASK_2KB;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_mirror_fifo.sv
// ----------------------------------------------------------------------------
// eeprom_mirror_fifo
// Synchronous show-ahead FIFO: the head entry is always presented on rd_data
// while empty is low, and is consumed on an edge with rd_en high.
// A write and a read in the same cycle on a full FIFO both succeed.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (flushes)
//   wr_en, wr_data    push request and entry
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry
//   full, empty       occupancy status
// ----------------------------------------------------------------------------
module eeprom_mirror_fifo
    import eeprom_mirror_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_rd = rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is allowed.
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage is reset too; it is only a few entries, and it makes
    // the head outputs read zero after reset instead of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/eeprom_mirror_rx.sv
// ----------------------------------------------------------------------------
// eeprom_mirror_rx
// Receives the serial mirror stream emitted by the EEPROM emulator on every
// internal write/erase, decodes each frame into (kind, word address, data)
// and queues it for the save-flash writer through a valid/ready FIFO.
// Ports:
//   SClk, Reset       system clock, asynchronous active-high reset
//   EEPROMSize        emulated size; sampled at frame end
//   SPIDo             serial data, MSB first
//   SPISel            frame select, active low
//   SPIClkRunning     qualifies SPIDo as a frame bit
//   FrameReady        downstream accepts the head entry
//   ErrorClear        clears FrameError and Overflow
//   FrameValid        head entry available
//   FrameKind/Addr/Data  head entry contents
//   Busy              frame in progress
//   FrameError        sticky: bad frame length or opcode
//   Overflow          sticky: valid frame dropped because the FIFO was full
// ----------------------------------------------------------------------------
module eeprom_mirror_rx
    import eeprom_mirror_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        SClk,
    input  logic        Reset,
    input  logic [1:0]  EEPROMSize,
    input  logic        SPIDo,
    input  logic        SPISel,
    input  logic        SPIClkRunning,
    input  logic        FrameReady,
    input  logic        ErrorClear,
    output logic        FrameValid,
    output logic [1:0]  FrameKind,
    output logic [9:0]  FrameAddr,
    output logic [15:0] FrameData,
    output logic        Busy,
    output logic        FrameError,
    output logic        Overflow
);

    rx_state_t      state_q, state_d;
    logic [31:0]    shreg_q, shreg_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;

    EEPROMSizeTypes size;
    logic [15:0]    command;
    logic [4:0]     op;
    logic [9:0]     masked_addr;
    mirror_entry_t  dec_entry;
    logic           dec_ok;
    logic           frame_end;
    logic           push, pop, err_evt, ovf_evt;
    mirror_entry_t  head_entry;
    logic           fifo_full, fifo_empty;

    // Frame FSM, shifter and bit counter.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!SPISel) begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (SPISel) begin
                    state_d = ST_IDLE;
                end else if (SPIClkRunning) begin
                    if (cnt_q < FRAME_LEN_LONG) begin
                        shreg_d = {shreg_q[30:0], SPIDo};
                    end
                    if (cnt_q < BIT_CNT_SAT) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
        endcase
    end

    // Decode, evaluated combinationally and used only on the frame-end edge.
    // A short frame's command sits in the low half of the shifter.
    always_comb begin
        size        = EEPROMSizeTypes'(EEPROMSize);
        command     = (cnt_q == FRAME_LEN_LONG) ? shreg_q[31:16] : shreg_q[15:0];
        op          = (size == eepromSize_128B) ? command[8:4] : command[12:8];
        masked_addr = command[9:0] & addr_mask(size);
        dec_entry   = '0;
        dec_ok      = 1'b0;
        if (cnt_q == FRAME_LEN_LONG) begin
            if (op[4:2] == 3'b101) begin
                dec_ok         = 1'b1;
                dec_entry.kind = mirrorKind_Write;
                dec_entry.addr = masked_addr;
                dec_entry.data = shreg_q[15:0];
            end else if (op == 5'b10001) begin
                dec_ok         = 1'b1;
                dec_entry.kind = mirrorKind_WriteAll;
                dec_entry.data = shreg_q[15:0];
            end
        end else if (cnt_q == FRAME_LEN_SHORT) begin
            if (op[4:2] == 3'b111) begin
                dec_ok         = 1'b1;
                dec_entry.kind = mirrorKind_Erase;
                dec_entry.addr = masked_addr;
                dec_entry.data = ERASE_DATA;
            end else if (op == 5'b10010) begin
                dec_ok         = 1'b1;
                dec_entry.kind = mirrorKind_EraseAll;
                dec_entry.data = ERASE_DATA;
            end
        end
    end

    // With no EEPROM emulated, frames are consumed silently.
    assign frame_end = (state_q == ST_SHIFT) && SPISel;
    assign push      = frame_end && dec_ok && (size != eepromSize_NoEEPROM);
    assign err_evt   = frame_end && !dec_ok && (size != eepromSize_NoEEPROM);
    assign pop       = !fifo_empty && FrameReady;
    assign ovf_evt   = push && fifo_full && !pop;

    // Sticky flags: a new event in the same cycle as a clear keeps the flag.
    always_comb begin
        err_d = ErrorClear ? 1'b0 : err_q;
        ovf_d = ErrorClear ? 1'b0 : ovf_q;
        if (err_evt) err_d = 1'b1;
        if (ovf_evt) ovf_d = 1'b1;
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    eeprom_mirror_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mirror_entry_t))
    ) u_fifo (
        .clk     (SClk),
        .rst     (Reset),
        .wr_en   (push),
        .wr_data (dec_entry),
        .rd_en   (FrameReady),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign FrameValid = !fifo_empty;
    assign FrameKind  = head_entry.kind;
    assign FrameAddr  = head_entry.addr;
    assign FrameData  = head_entry.data;
    assign Busy       = (state_q == ST_SHIFT);
    assign FrameError = err_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_eeprom_mirror_rx.sv
// ----------------------------------------------------------------------------
// tb_eeprom_mirror_rx
// Directed bench for eeprom_mirror_rx: drives emulator-shaped mirror frames
// and compares the queued entries and status flags against hand-computed
// values.
// ----------------------------------------------------------------------------
module tb_eeprom_mirror_rx;

    localparam logic [1:0] SZ_128B = 2'd0;
    localparam logic [1:0] SZ_1KB  = 2'd1;
    localparam logic [1:0] SZ_2KB  = 2'd2;
    localparam logic [1:0] SZ_NONE = 2'd3;

    localparam logic [1:0] K_WRITE     = 2'd0;
    localparam logic [1:0] K_WRITEALL  = 2'd1;
    localparam logic [1:0] K_ERASE     = 2'd2;
    localparam logic [1:0] K_ERASEALL  = 2'd3;

    logic        SClk = 1'b0;
    logic        Reset;
    logic [1:0]  EEPROMSize;
    logic        SPIDo;
    logic        SPISel;
    logic        SPIClkRunning;
    logic        FrameReady;
    logic        ErrorClear;
    logic        FrameValid;
    logic [1:0]  FrameKind;
    logic [9:0]  FrameAddr;
    logic [15:0] FrameData;
    logic        Busy;
    logic        FrameError;
    logic        Overflow;

    int n_checks = 0;
    int n_errors = 0;

    eeprom_mirror_rx #(.DEPTH(4)) dut (
        .SClk          (SClk),
        .Reset         (Reset),
        .EEPROMSize    (EEPROMSize),
        .SPIDo         (SPIDo),
        .SPISel        (SPISel),
        .SPIClkRunning (SPIClkRunning),
        .FrameReady    (FrameReady),
        .ErrorClear    (ErrorClear),
        .FrameValid    (FrameValid),
        .FrameKind     (FrameKind),
        .FrameAddr     (FrameAddr),
        .FrameData     (FrameData),
        .Busy          (Busy),
        .FrameError    (FrameError),
        .Overflow      (Overflow)
    );

    always #5 SClk = ~SClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge SClk);
        #1;
    endtask

    // One emulator frame: SPISel falls, nbits qualified bits MSB first, an
    // optional unqualified trailing cycle, then SPISel rises (frame-end edge).
    task automatic send_frame(input logic [31:0] bits, input int nbits,
                              input bit trailing, input bit pop_at_end);
        SPISel        = 1'b0;
        SPIClkRunning = 1'b0;
        tick();
        check("busy_start", Busy, 1);
        for (int i = 0; i < nbits; i++) begin
            SPIClkRunning = 1'b1;
            SPIDo         = bits[nbits-1-i];
            tick();
        end
        if (trailing) begin
            SPIClkRunning = 1'b0;
            SPIDo         = 1'b1;
            tick();
        end
        SPIClkRunning = 1'b0;
        SPIDo         = 1'b0;
        SPISel        = 1'b1;
        FrameReady    = pop_at_end;
        tick();
        FrameReady    = 1'b0;
        check("busy_end", Busy, 0);
    endtask

    task automatic expect_head(input string tag, input logic [1:0] kind,
                               input logic [9:0] addr, input logic [15:0] data);
        check({tag, "_valid"}, FrameValid, 1);
        check({tag, "_kind"},  FrameKind,  kind);
        check({tag, "_addr"},  FrameAddr,  addr);
        check({tag, "_data"},  FrameData,  data);
    endtask

    task automatic pop_one();
        FrameReady = 1'b1;
        tick();
        FrameReady = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        EEPROMSize    = SZ_1KB;
        SPIDo         = 1'b0;
        SPISel        = 1'b1;
        SPIClkRunning = 1'b0;
        FrameReady    = 1'b0;
        ErrorClear    = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", FrameValid, 0);
        check("rst_busy",  Busy,       0);
        check("rst_err",   FrameError, 0);
        check("rst_ovf",   Overflow,   0);
        check("rst_kind",  FrameKind,  0);
        check("rst_addr",  FrameAddr,  0);
        check("rst_data",  FrameData,  0);
        Reset = 1'b0;
        tick();

        // 1KB write; head must hold while not accepted
        EEPROMSize = SZ_1KB;
        send_frame({16'h1423, 16'hBEEF}, 32, 1'b0, 1'b0);
        expect_head("wr1k", K_WRITE, 10'h023, 16'hBEEF);
        tick();
        expect_head("wr1k_hold", K_WRITE, 10'h023, 16'hBEEF);
        pop_one();
        check("wr1k_popped", FrameValid, 0);

        // 1KB erase with trailing unqualified cycle
        send_frame({16'h0000, 16'h1C05}, 16, 1'b1, 1'b0);
        expect_head("er1k", K_ERASE, 10'h005, 16'hFFFF);
        pop_one();

        // 1KB write-all
        send_frame({16'h1100, 16'h5A5A}, 32, 1'b0, 1'b0);
        expect_head("wall", K_WRITEALL, 10'h000, 16'h5A5A);
        pop_one();

        // 128B write (opcode from command[8:4], 6-bit mask)
        EEPROMSize = SZ_128B;
        send_frame({16'h0147, 16'h1234}, 32, 1'b0, 1'b0);
        expect_head("wr128", K_WRITE, 10'h007, 16'h1234);
        pop_one();

        // 2KB erase-all
        EEPROMSize = SZ_2KB;
        send_frame({16'h0000, 16'h1200}, 16, 1'b0, 1'b0);
        expect_head("eall2k", K_ERASEALL, 10'h000, 16'hFFFF);
        pop_one();

        // Overflow: five frames into a four-entry FIFO
        EEPROMSize = SZ_1KB;
        for (int i = 0; i < 4; i++) begin
            send_frame({16'h1400 + 16'(i), 16'h1000 + 16'(i)}, 32, 1'b0, 1'b0);
        end
        check("ovf_before", Overflow, 0);
        send_frame({16'h1404, 16'h1004}, 32, 1'b0, 1'b0);
        check("ovf_set", Overflow, 1);
        FrameReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_head("ovf_drain", K_WRITE, 10'(i), 16'h1000 + 16'(i));
            tick();
        end
        FrameReady = 1'b0;
        check("ovf_empty", FrameValid, 0);
        ErrorClear = 1'b1;
        tick();
        ErrorClear = 1'b0;
        check("ovf_clear", Overflow, 0);

        // Full FIFO with a pop on the frame-end edge: the push succeeds
        for (int i = 0; i < 4; i++) begin
            send_frame({16'h1410 + 16'(i), 16'h2000 + 16'(i)}, 32, 1'b0, 1'b0);
        end
        send_frame({16'h1420, 16'h2004}, 32, 1'b0, 1'b1);
        check("fullpp_ovf", Overflow, 0);
        FrameReady = 1'b1;
        for (int i = 1; i < 4; i++) begin
            expect_head("fullpp_old", K_WRITE, 10'h010 + 10'(i), 16'h2000 + 16'(i));
            tick();
        end
        expect_head("fullpp_new", K_WRITE, 10'h020, 16'h2004);
        tick();
        FrameReady = 1'b0;
        check("fullpp_empty", FrameValid, 0);

        // 20-bit frame: error, no push; clear
        send_frame(32'h000ABCDE, 20, 1'b0, 1'b0);
        check("bad_err",   FrameError, 1);
        check("bad_valid", FrameValid, 0);
        ErrorClear = 1'b1;
        tick();
        ErrorClear = 1'b0;
        check("bad_clear", FrameError, 0);

        // No EEPROM: valid write is swallowed without error
        EEPROMSize = SZ_NONE;
        send_frame({16'h1423, 16'hBEEF}, 32, 1'b0, 1'b0);
        check("none_valid", FrameValid, 0);
        check("none_err",   FrameError, 0);

        // Reset mid-frame flushes a queued entry and aborts the frame
        EEPROMSize = SZ_1KB;
        send_frame({16'h1423, 16'hBEEF}, 32, 1'b0, 1'b0);
        check("mid_queued", FrameValid, 1);
        SPISel = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            SPIClkRunning = 1'b1;
            SPIDo         = i[0];
            tick();
        end
        check("mid_busy", Busy, 1);
        Reset = 1'b1;
        #2;
        check("mid_rst_busy",  Busy,       0);
        check("mid_rst_valid", FrameValid, 0);
        SPIClkRunning = 1'b0;
        SPISel        = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        send_frame({16'h17FF, 16'h0001}, 32, 1'b0, 1'b0);
        expect_head("post_rst", K_WRITE, 10'h1FF, 16'h0001);
        pop_one();
        check("post_rst_empty", FrameValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
